i2c_writer: RTL and testbench

I2C_WRITER -- requirements
Module: i2c_writer

---
 rtl/i2c_writer_if.sv | 26 ++
 rtl/i2c_writer.sv | 159 +++++++++++++++
 tb/tb_i2c_writer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_writer_if.sv
// Source-read and window-buffer-write bus between i2c_writer and its neighbours.
// master = the writer itself, slave = source memory / window buffer side.
interface i2c_writer_if;
    logic         src_rd_en;
    logic [11:0]  src_rd_addr;
    logic [127:0] src_rd_data;
    logic         buf_empty;
    logic         i2c_ready;
    logic         i2c_done;
    logic         ifm_wr_en;
    logic [4:0]   ifm_wr_addr;
    logic [127:0] pixels_in;
    logic [3:0]   valid_num;

    modport master (
        output src_rd_en, src_rd_addr, i2c_ready, i2c_done,
        output ifm_wr_en, ifm_wr_addr, pixels_in, valid_num,
        input  src_rd_data, buf_empty
    );

    modport slave (
        input  src_rd_en, src_rd_addr, i2c_ready, i2c_done,
        input  ifm_wr_en, ifm_wr_addr, pixels_in, valid_num,
        output src_rd_data, buf_empty
    );
endinterface

// File: rtl/i2c_writer.sv
// Fills the kernel window buffer: reads ksize*ksize source words and writes them out in order.
// Optional macro I2C_ZERO_PAD_EN: signed window origin, out-of-map positions written as zero.
module i2c_writer (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   ksize,
    input  logic         ch_mode,
    input  logic [5:0]   win_row,
    input  logic [5:0]   win_col,
    input  logic [5:0]   ifm_height,
    input  logic [5:0]   ifm_width,
    output logic         busy,
    output logic         cfg_err,
    i2c_writer_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARM0  = 3'd1;
    localparam logic [2:0] ARM1  = 3'd2;
    localparam logic [2:0] FETCH = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [2:0]   ksize_q;
    logic         ch_mode_q;
    logic [5:0]   row_q, col_q, height_q, width_q;
    logic [2:0]   kx_q, ky_q;
    logic [4:0]   k_q;
    logic         s1_vld_q, s1_pad_q;
    logic [4:0]   s1_idx_q;
    logic         wr_en_q;
    logic [4:0]   wr_addr_q;
    logic [127:0] pix_q;
    logic [3:0]   vnum_q;
    logic         cfg_err_q;

    logic         ksize_ok, accept, reject, fetch, in_range, last_rd, last_wr;
    logic [5:0]   n_m1;
    logic [7:0]   row_ext, col_ext;
    logic [11:0]  addr;

    assign ksize_ok = (ksize != 3'd0) && (ksize <= 3'd5);
    assign accept   = (state_q == IDLE) && start && bus.buf_empty && ksize_ok;
    assign reject   = (state_q == IDLE) && start && bus.buf_empty && !ksize_ok;
    assign fetch    = (state_q == FETCH);
    assign n_m1     = ({3'b000, ksize_q} * {3'b000, ksize_q}) - 6'd1;
    assign last_rd  = ({1'b0, k_q} == n_m1);
    assign last_wr  = wr_en_q && ({1'b0, wr_addr_q} == n_m1);

`ifdef I2C_ZERO_PAD_EN
    assign row_ext  = {{2{row_q[5]}}, row_q} + {5'd0, ky_q};
    assign col_ext  = {{2{col_q[5]}}, col_q} + {5'd0, kx_q};
    assign in_range = !row_ext[7] && (row_ext < {2'b00, height_q}) &&
                      !col_ext[7] && (col_ext < {2'b00, width_q});
`else
    logic unused_height;
    assign unused_height = ^height_q;
    assign row_ext  = {2'b00, row_q} + {5'd0, ky_q};
    assign col_ext  = {2'b00, col_q} + {5'd0, kx_q};
    assign in_range = 1'b1;
`endif

    // 12-bit arithmetic gives the required truncation for free.
    assign addr = {4'd0, row_ext} * {6'd0, width_q} + {4'd0, col_ext};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ARM0;
            ARM0:    state_d = ARM1;
            ARM1:    state_d = FETCH;
            FETCH:   if (last_rd) state_d = DRAIN;
            DRAIN:   if (last_wr) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cfg_err_q <= 1'b0;
            ksize_q   <= 3'd0;
            ch_mode_q <= 1'b0;
            row_q     <= 6'd0;
            col_q     <= 6'd0;
            height_q  <= 6'd0;
            width_q   <= 6'd0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= reject;
            if (accept) begin
                ksize_q   <= ksize;
                ch_mode_q <= ch_mode;
                row_q     <= win_row;
                col_q     <= win_col;
                height_q  <= ifm_height;
                width_q   <= ifm_width;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            kx_q <= 3'd0;
            ky_q <= 3'd0;
            k_q  <= 5'd0;
        end else if (state_q == ARM0) begin
            kx_q <= 3'd0;
            ky_q <= 3'd0;
            k_q  <= 5'd0;
        end else if (fetch) begin
            k_q <= k_q + 5'd1;
            if (kx_q == ksize_q - 3'd1) begin
                kx_q <= 3'd0;
                ky_q <= ky_q + 3'd1;
            end else begin
                kx_q <= kx_q + 3'd1;
            end
        end
    end

    // Stage 1 tracks the read in flight; stage 2 registers the returned word as the write.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_pad_q  <= 1'b0;
            s1_idx_q  <= 5'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            pix_q     <= '0;
            vnum_q    <= 4'd0;
        end else begin
            s1_vld_q  <= fetch;
            s1_pad_q  <= fetch && !in_range;
            s1_idx_q  <= k_q;
            wr_en_q   <= s1_vld_q;
            wr_addr_q <= s1_vld_q ? s1_idx_q : 5'd0;
            if (s1_vld_q && !s1_pad_q) begin
                pix_q <= ch_mode_q ? bus.src_rd_data : {80'd0, bus.src_rd_data[47:0]};
            end else begin
                pix_q <= '0;
            end
            vnum_q <= s1_vld_q ? (ch_mode_q ? 4'b1000 : 4'b0011) : 4'd0;
        end
    end

    assign bus.src_rd_en   = fetch && in_range;
    assign bus.src_rd_addr = (fetch && in_range) ? addr : 12'd0;
    assign bus.i2c_ready   = (state_q == IDLE) || (state_q == DONE);
    assign bus.i2c_done    = (state_q == DONE);
    assign bus.ifm_wr_en   = wr_en_q;
    assign bus.ifm_wr_addr = wr_addr_q;
    assign bus.pixels_in   = pix_q;
    assign bus.valid_num   = vnum_q;
    assign busy            = (state_q != IDLE);
    assign cfg_err         = cfg_err_q;
endmodule

// File: tb/tb_i2c_writer.sv
// Scoreboard bench for i2c_writer: expected reads/writes/done are queued at start, popped on output.
module tb_i2c_writer;
    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] ksize = 3'd0;
    logic       ch_mode = 1'b0;
    logic [5:0] win_row = 6'd0, win_col = 6'd0, ifm_height = 6'd0, ifm_width = 6'd0;
    logic       busy, cfg_err;

`ifdef I2C_ZERO_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    i2c_writer_if bus ();

    i2c_writer dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .start      (start),
        .ksize      (ksize),
        .ch_mode    (ch_mode),
        .win_row    (win_row),
        .win_col    (win_col),
        .ifm_height (ifm_height),
        .ifm_width  (ifm_width),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    typedef struct {logic [11:0] addr; int cyc;} rd_t;
    typedef struct {logic [4:0] addr; logic [127:0] data; logic [3:0] vnum; int cyc;} wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  done_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  n_done = 0;
    bit  ones_mode = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [127:0] model_word(input logic [11:0] a);
        logic [127:0] w;
        if (ones_mode) return '1;
        for (int i = 0; i < 8; i++) w[16*i +: 16] = {a, 4'(i)};
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Source memory: data valid the cycle after the read strobe, junk otherwise.
    always @(posedge clock) begin
        if (bus.src_rd_en) bus.src_rd_data <= model_word(bus.src_rd_addr);
        else               bus.src_rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    rd_t re;
    wr_t we;
    int  de;
    always @(negedge clock) begin
        if (bus.src_rd_en) begin
            if (rd_q.size() == 0) check_eq("rd_unexpected", 1, 0);
            else begin
                re = rd_q.pop_front();
                check_eq("rd_addr", bus.src_rd_addr, re.addr);
                check_eq("rd_cycle", cyc, re.cyc);
            end
        end
        if (bus.ifm_wr_en) begin
            if (wr_q.size() == 0) check_eq("wr_unexpected", 1, 0);
            else begin
                we = wr_q.pop_front();
                check_eq("wr_addr", bus.ifm_wr_addr, we.addr);
                check_eq("wr_data", bus.pixels_in, we.data);
                check_eq("wr_vnum", bus.valid_num, we.vnum);
                check_eq("wr_cycle", cyc, we.cyc);
            end
        end else begin
            check_eq("idle_wr_zero", bus.pixels_in | 128'(bus.valid_num), 0);
        end
        if (bus.i2c_done) begin
            n_done++;
            check_eq("done_ready", bus.i2c_ready, 1);
            if (done_q.size() == 0) check_eq("done_unexpected", 1, 0);
            else begin
                de = done_q.pop_front();
                check_eq("done_cycle", cyc, de);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, bus.i2c_ready, 1);
        check_eq({tag, "_cfg_err"}, cfg_err, 0);
        check_eq({tag, "_done"}, bus.i2c_done, 0);
        check_eq({tag, "_wr_en"}, bus.ifm_wr_en, 0);
        check_eq({tag, "_rd_en"}, bus.src_rd_en, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_wr_addr"}, bus.ifm_wr_addr, 0);
        check_eq({tag, "_rd_addr"}, bus.src_rd_addr, 0);
        check_eq({tag, "_pixels"}, bus.pixels_in, 0);
        check_eq({tag, "_vnum"}, bus.valid_num, 0);
    endtask

    // Called just after a negedge; start is sampled at the next posedge (edge E).
    task automatic do_fill(input logic [2:0] ks, input logic chm, input logic [5:0] r0,
                           input logic [5:0] c0, input logic [5:0] h, input logic [5:0] w,
                           input int abort_k, input bit drain_start);
        int ce, n, k, r, c, done_before;
        bit pad;
        logic [11:0] a;
        logic [127:0] d;
        ksize = ks; ch_mode = chm; win_row = r0; win_col = c0;
        ifm_height = h; ifm_width = w; bus.buf_empty = 1'b1; start = 1'b1;
        ce = cyc + 1;
        n = int'(ks) * int'(ks);
        done_before = n_done;
        k = 0;
        for (int ky = 0; ky < int'(ks); ky++) begin
            for (int kx = 0; kx < int'(ks); kx++) begin
                r = int'(r0); c = int'(c0);
                if (PadEn && r0[5]) r -= 64;
                if (PadEn && c0[5]) c -= 64;
                r += ky; c += kx;
                pad = PadEn && (r < 0 || r >= int'(h) || c < 0 || c >= int'(w));
                a = 12'((r * int'(w) + c) & 32'hFFF);
                if (!pad) rd_q.push_back('{addr: a, cyc: ce + 2 + k});
                d = pad ? '0 : model_word(a);
                if (!chm) d[127:48] = '0;
                wr_q.push_back('{addr: 5'(k), data: d, vnum: chm ? 4'b1000 : 4'b0011,
                                 cyc: ce + 4 + k});
                k++;
            end
        end
        done_q.push_back(ce + 4 + n);
        @(negedge clock);
        start = 1'b0;
        check_eq("arm_busy", busy, 1);
        check_eq("arm_ready", bus.i2c_ready, 0);
        for (int t = 0; t < 100; t++) begin
            if (abort_k >= 0 && cyc == ce + 2 + abort_k) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("mid_rst");
                rd_q.delete(); wr_q.delete(); done_q.delete();
                @(negedge clock);
                rst_n = 1'b1;
                return;
            end
            start = (drain_start && cyc == ce + 2 + n);
            if (rd_q.size() + wr_q.size() + done_q.size() == 0) break;
            @(negedge clock);
        end
        start = 1'b0;
        check_eq("fill_complete", rd_q.size() + wr_q.size() + done_q.size(), 0);
        rd_q.delete(); wr_q.delete(); done_q.delete();
        @(negedge clock);
        @(negedge clock);
        check_eq("post_busy", busy, 0);
        check_eq("post_ready", bus.i2c_ready, 1);
        check_eq("done_count", n_done - done_before, 1);
    endtask

    task automatic reject_test(input logic [2:0] ks);
        ksize = ks; bus.buf_empty = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_eq("rej_cfg_err", cfg_err, 1);
        check_eq("rej_busy", busy, 0);
        check_eq("rej_ready", bus.i2c_ready, 1);
        @(negedge clock);
        check_eq("rej_cfg_err_once", cfg_err, 0);
        check_eq("rej_busy2", busy, 0);
    endtask

    initial begin
        bus.buf_empty = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clock);

        do_fill(3'd3, 1'b1, 6'd0, 6'd0, 6'd8, 6'd8, -1, 1'b0);

        ones_mode = 1'b1;
        do_fill(3'd1, 1'b0, 6'd5, 6'd7, 6'd16, 6'd16, -1, 1'b0);
        ones_mode = 1'b0;

        // Start while the buffer is still full must be ignored.
        ksize = 3'd3; bus.buf_empty = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_eq("full_busy", busy, 0);
        check_eq("full_ready", bus.i2c_ready, 1);
        check_eq("full_cfg_err", cfg_err, 0);
        @(negedge clock);
        check_eq("full_busy2", busy, 0);
        bus.buf_empty = 1'b1;

        reject_test(3'd6);
        reject_test(3'd0);

        do_fill(3'd5, 1'b1, 6'd1, 6'd2, 6'd20, 6'd20, 4, 1'b0);
        do_fill(3'd5, 1'b0, 6'd2, 6'd3, 6'd30, 6'd20, -1, 1'b0);

        do_fill(3'd2, 1'b1, 6'd0, 6'd0, 6'd8, 6'd8, -1, 1'b1);

`ifdef I2C_ZERO_PAD_EN
        do_fill(3'd3, 1'b1, 6'h3F, 6'h3F, 6'd8, 6'd8, -1, 1'b0);
        do_fill(3'd3, 1'b0, 6'd6, 6'd6, 6'd8, 6'd8, -1, 1'b0);
`else
        do_fill(3'd2, 1'b1, 6'd63, 6'd63, 6'd40, 6'd63, -1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
